// File: rtl/blob_extent_tracker_if.sv
// Pixel fetch bus between the blob tracker and the frame store.
// The tracker (master) issues a one-cycle req with the x/y coordinate to
// fetch. The frame store (slave) answers later with valid plus the pixel's
// HSV value and its background model:
//   gray/mean - current gray level and background mean
//   bg_var    - background variance threshold
interface blob_extent_tracker_if #(
  parameter int CW = 11
);
  logic          req;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          valid;
  logic [8:0]    h;
  logic [7:0]    s;
  logic [7:0]    v;
  logic [7:0]    gray;
  logic [7:0]    mean;
  logic [15:0]   bg_var;

  modport master (
    output req, x, y,
    input  valid, h, s, v, gray, mean, bg_var
  );

  modport slave (
    input  req, x, y,
    output valid, h, s, v, gray, mean, bg_var
  );
endinterface

// File: rtl/blob_extent_tracker.sv
// blob_extent_tracker: scans a frame through the pixel fetch bus and drops
// background pixels using a mean/variance test. Each remaining pixel is
// classified against NCH HSV windows. For every channel the block tracks the
// extreme points (up/down/left/right) and a match count. Results are
// double-buffered: the output registers load only when a frame completes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, continuous   start a scan / rescan after every frame
//   cfg_*               per-channel HSV windows (hue 9b, S/V 8b per channel)
//   pix                 pixel fetch bus (master side)
//   busy                scan in progress
//   valid               one-cycle pulse, result buses just updated
//   up/down/left/right  per-channel extreme coordinates, CW bits per channel
//   count, found        per-channel match count (20b) and count >= MIN_CNT
//   frame_cnt           completed frames, wraps
//
// state  | meaning
// S_IDLE | waiting for start, working registers held clear
// S_REQ  | issue fetch request for (x, y)
// S_WAIT | wait for pixel data, then process and advance
// S_OUT  | publish the frame result, restart or go idle
module blob_extent_tracker #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 1,
  parameter int NCH       = 2,
  parameter int CW        = 11,
  parameter int MIN_CNT   = 16,
  parameter int NOT_FOUND = 2023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [NCH*9-1:0]      cfg_hmin,
  input  logic [NCH*9-1:0]      cfg_hmax,
  input  logic [NCH*8-1:0]      cfg_smin,
  input  logic [NCH*8-1:0]      cfg_smax,
  input  logic [NCH*8-1:0]      cfg_vmin,
  input  logic [NCH*8-1:0]      cfg_vmax,
  blob_extent_tracker_if.master pix,
  output logic                  busy,
  output logic                  valid,
  output logic [NCH*CW-1:0]     up_x,
  output logic [NCH*CW-1:0]     up_y,
  output logic [NCH*CW-1:0]     down_x,
  output logic [NCH*CW-1:0]     down_y,
  output logic [NCH*CW-1:0]     left_x,
  output logic [NCH*CW-1:0]     left_y,
  output logic [NCH*CW-1:0]     right_x,
  output logic [NCH*CW-1:0]     right_y,
  output logic [NCH*20-1:0]     count,
  output logic [NCH-1:0]        found,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  localparam logic [CW-1:0] NF = CW'(NOT_FOUND);

  state_t state, state_nxt;

  logic [CW-1:0] cx, cy;
  logic          req_c;
  logic          wk_clr;
  logic          pix_acc;
  logic          x_wrap, y_wrap, frame_end;

  logic [7:0]    diff;
  logic [15:0]   diff_sq;
  logic          is_bg;
  logic [NCH-1:0] ch_match;
  logic [NCH-1:0] hit;

  logic [CW-1:0] wk_ux [NCH], wk_uy [NCH], wk_dx [NCH], wk_dy [NCH];
  logic [CW-1:0] wk_lx [NCH], wk_ly [NCH], wk_rx [NCH], wk_ry [NCH];
  logic [19:0]   wk_cnt [NCH];
  logic [CW-1:0] n_ux [NCH], n_uy [NCH], n_dx [NCH], n_dy [NCH];
  logic [CW-1:0] n_lx [NCH], n_ly [NCH], n_rx [NCH], n_ry [NCH];
  logic [19:0]   n_cnt [NCH];

  assign pix.req = req_c;
  assign pix.x   = cx;
  assign pix.y   = cy;

  // Scan position bookkeeping; arithmetic done in 32 bits so x+STEP never wraps.
  assign x_wrap    = (int'(cx) + STEP_X) >= WIDTH;
  assign y_wrap    = (int'(cy) + STEP_Y) >= HEIGHT;
  assign frame_end = x_wrap && y_wrap;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    busy      = 1'b0;
    valid     = 1'b0;
    wk_clr    = 1'b0;
    pix_acc   = 1'b0;
    case (state)
      S_IDLE: begin
        wk_clr = 1'b1;
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        req_c     = 1'b1;
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (pix.valid) begin
          pix_acc   = 1'b1;
          state_nxt = frame_end ? S_OUT : S_REQ;
        end
      end
      S_OUT: begin
        busy  = 1'b1;
        valid = 1'b1;
        if (continuous) begin
          wk_clr    = 1'b1;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- pixel classification ----------------
  always_comb begin
    diff    = (pix.gray >= pix.mean) ? (pix.gray - pix.mean) : (pix.mean - pix.gray);
    diff_sq = {8'd0, diff} * {8'd0, diff};
    is_bg   = diff_sq <= pix.bg_var;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [8:0] hmin, hmax;
    logic [7:0] smin, smax, vmin, vmax;
    logic       h_ok, s_ok, v_ok;

    assign hmin = cfg_hmin[9*k +: 9];
    assign hmax = cfg_hmax[9*k +: 9];
    assign smin = cfg_smin[8*k +: 8];
    assign smax = cfg_smax[8*k +: 8];
    assign vmin = cfg_vmin[8*k +: 8];
    assign vmax = cfg_vmax[8*k +: 8];

    // hmin > hmax means the hue window wraps through 0/359.
    assign h_ok = (hmin <= hmax) ? ((pix.h >= hmin) && (pix.h <= hmax))
                                 : ((pix.h >= hmin) || (pix.h <= hmax));
    assign s_ok = (pix.s >= smin) && (pix.s <= smax);
    assign v_ok = (pix.v >= vmin) && (pix.v <= vmax);

    assign ch_match[k] = !is_bg && h_ok && s_ok && v_ok;
  end

  // Next working values if the current pixel were accepted. The output
  // registers load from these directly so the last pixel is included in
  // the result published together with valid.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      n_ux[k]  = wk_ux[k];
      n_uy[k]  = wk_uy[k];
      n_dx[k]  = wk_dx[k];
      n_dy[k]  = wk_dy[k];
      n_lx[k]  = wk_lx[k];
      n_ly[k]  = wk_ly[k];
      n_rx[k]  = wk_rx[k];
      n_ry[k]  = wk_ry[k];
      n_cnt[k] = wk_cnt[k];
      if (ch_match[k]) begin
        if (wk_cnt[k] != '1) n_cnt[k] = wk_cnt[k] + 20'd1;
        if (cy < wk_uy[k]) begin
          n_ux[k] = cx;
          n_uy[k] = cy;
        end
        if (cy >= wk_dy[k]) begin
          n_dx[k] = cx;
          n_dy[k] = cy;
        end
        if (cx <= wk_lx[k]) begin
          n_lx[k] = cx;
          n_ly[k] = cy;
        end
        if (cx > wk_rx[k]) begin
          n_rx[k] = cx;
          n_ry[k] = cy;
        end
      end
      hit[k] = n_cnt[k] >= 20'(MIN_CNT);
    end
  end

  // ---------------- working registers ----------------
  always_ff @(posedge clk) begin
    if (rst || wk_clr) begin
      for (int k = 0; k < NCH; k++) begin
        wk_ux[k]  <= NF;
        wk_uy[k]  <= NF;
        wk_dx[k]  <= '0;
        wk_dy[k]  <= '0;
        wk_lx[k]  <= NF;
        wk_ly[k]  <= NF;
        wk_rx[k]  <= '0;
        wk_ry[k]  <= '0;
        wk_cnt[k] <= '0;
      end
    end else if (pix_acc) begin
      for (int k = 0; k < NCH; k++) begin
        wk_ux[k]  <= n_ux[k];
        wk_uy[k]  <= n_uy[k];
        wk_dx[k]  <= n_dx[k];
        wk_dy[k]  <= n_dy[k];
        wk_lx[k]  <= n_lx[k];
        wk_ly[k]  <= n_ly[k];
        wk_rx[k]  <= n_rx[k];
        wk_ry[k]  <= n_ry[k];
        wk_cnt[k] <= n_cnt[k];
      end
    end
  end

  // ---------------- scan position and result buffer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cx        <= '0;
      cy        <= '0;
      frame_cnt <= '0;
      found     <= '0;
      count     <= '0;
      up_x      <= {NCH{NF}};
      up_y      <= {NCH{NF}};
      down_x    <= {NCH{NF}};
      down_y    <= {NCH{NF}};
      left_x    <= {NCH{NF}};
      left_y    <= {NCH{NF}};
      right_x   <= {NCH{NF}};
      right_y   <= {NCH{NF}};
    end else if (state == S_IDLE) begin
      cx <= '0;
      cy <= '0;
    end else if (pix_acc) begin
      if (x_wrap) begin
        cx <= '0;
        if (y_wrap) cy <= '0;
        else        cy <= cy + CW'(STEP_Y);
      end else begin
        cx <= cx + CW'(STEP_X);
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
        for (int k = 0; k < NCH; k++) begin
          found[k]               <= hit[k];
          count[20*k +: 20]      <= n_cnt[k];
          up_x[CW*k +: CW]       <= hit[k] ? n_ux[k] : NF;
          up_y[CW*k +: CW]       <= hit[k] ? n_uy[k] : NF;
          down_x[CW*k +: CW]     <= hit[k] ? n_dx[k] : NF;
          down_y[CW*k +: CW]     <= hit[k] ? n_dy[k] : NF;
          left_x[CW*k +: CW]     <= hit[k] ? n_lx[k] : NF;
          left_y[CW*k +: CW]     <= hit[k] ? n_ly[k] : NF;
          right_x[CW*k +: CW]    <= hit[k] ? n_rx[k] : NF;
          right_y[CW*k +: CW]    <= hit[k] ? n_ry[k] : NF;
        end
      end
    end
  end

endmodule

// File: tb/tb_blob_extent_tracker.sv
// Directed bench for blob_extent_tracker on an 8x4 frame with two channels.
// Two instances run in lockstep on identical stimulus: one with MIN_CNT=1,
// one with MIN_CNT=4.
module tb_blob_extent_tracker;
  localparam int CW  = 11;
  localparam int NCH = 2;
  localparam int NF  = 2023;

  typedef struct {
    int vec; int x; int y; int h; int vr;
  } pix_t;

  typedef struct {
    int vec; int ch; int cnt;
    int ux; int uy; int dx; int dy; int lx; int ly; int rx; int ry;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, continuous;
  logic [NCH*9-1:0] cfg_hmin, cfg_hmax;
  logic [NCH*8-1:0] cfg_smin, cfg_smax, cfg_vmin, cfg_vmax;

  logic a_busy, a_valid, b_busy, b_valid;
  logic [NCH*CW-1:0] a_ux, a_uy, a_dx, a_dy, a_lx, a_ly, a_rx, a_ry;
  logic [NCH*CW-1:0] b_ux, b_uy, b_dx, b_dy, b_lx, b_ly, b_rx, b_ry;
  logic [NCH*20-1:0] a_cnt, b_cnt;
  logic [NCH-1:0]    a_found, b_found;
  logic [15:0]       a_fcnt, b_fcnt;

  blob_extent_tracker_if #(.CW(CW)) pa ();
  blob_extent_tracker_if #(.CW(CW)) pb ();

  blob_extent_tracker #(.WIDTH(8), .HEIGHT(4), .STEP_X(1), .STEP_Y(1), .NCH(NCH),
                        .CW(CW), .MIN_CNT(1), .NOT_FOUND(NF)) dut_a (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .cfg_hmin(cfg_hmin), .cfg_hmax(cfg_hmax), .cfg_smin(cfg_smin), .cfg_smax(cfg_smax),
    .cfg_vmin(cfg_vmin), .cfg_vmax(cfg_vmax), .pix(pa.master),
    .busy(a_busy), .valid(a_valid),
    .up_x(a_ux), .up_y(a_uy), .down_x(a_dx), .down_y(a_dy),
    .left_x(a_lx), .left_y(a_ly), .right_x(a_rx), .right_y(a_ry),
    .count(a_cnt), .found(a_found), .frame_cnt(a_fcnt));

  blob_extent_tracker #(.WIDTH(8), .HEIGHT(4), .STEP_X(1), .STEP_Y(1), .NCH(NCH),
                        .CW(CW), .MIN_CNT(4), .NOT_FOUND(NF)) dut_b (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .cfg_hmin(cfg_hmin), .cfg_hmax(cfg_hmax), .cfg_smin(cfg_smin), .cfg_smax(cfg_smax),
    .cfg_vmin(cfg_vmin), .cfg_vmax(cfg_vmax), .pix(pb.master),
    .busy(b_busy), .valid(b_valid),
    .up_x(b_ux), .up_y(b_uy), .down_x(b_dx), .down_y(b_dy),
    .left_x(b_lx), .left_y(b_ly), .right_x(b_rx), .right_y(b_ry),
    .count(b_cnt), .found(b_found), .frame_cnt(b_fcnt));

  initial forever #5 clk = ~clk;

  int n_applied = 0;
  int n_miss    = 0;

  bit m_fg  [32];
  int m_h   [32];
  int m_var [32];

  pix_t ptab [14];
  exp_t etab [12];

  task automatic chk(input string name, input int act, input int exp);
    n_applied++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sl(input logic [NCH*CW-1:0] bus, input int ch);
    return int'(bus[ch*CW +: CW]);
  endfunction

  task automatic chk_res(input string tag, input int mc, input exp_t e,
                         input logic [NCH*CW-1:0] ux, uy, dx, dy, lx, ly, rx, ry,
                         input logic [NCH*20-1:0] cnt, input logic [NCH-1:0] fnd);
    bit f;
    string p;
    f = (e.cnt >= mc);
    p = $sformatf("%s v%0d ch%0d", tag, e.vec, e.ch);
    chk({p, " count"}, int'(cnt[e.ch*20 +: 20]), e.cnt);
    chk({p, " found"}, int'(fnd[e.ch]), int'(f));
    chk({p, " up_x"},    sl(ux, e.ch), f ? e.ux : NF);
    chk({p, " up_y"},    sl(uy, e.ch), f ? e.uy : NF);
    chk({p, " down_x"},  sl(dx, e.ch), f ? e.dx : NF);
    chk({p, " down_y"},  sl(dy, e.ch), f ? e.dy : NF);
    chk({p, " left_x"},  sl(lx, e.ch), f ? e.lx : NF);
    chk({p, " left_y"},  sl(ly, e.ch), f ? e.ly : NF);
    chk({p, " right_x"}, sl(rx, e.ch), f ? e.rx : NF);
    chk({p, " right_y"}, sl(ry, e.ch), f ? e.ry : NF);
  endtask

  // Frame store model: data returned in the cycle after each req.
  bit pend_a, pend_b;
  int ax, ay, bx, by;
  initial begin
    pend_a = 0; pend_b = 0; ax = 0; ay = 0; bx = 0; by = 0;
    pa.valid = 0; pa.h = '0; pa.s = '0; pa.v = '0; pa.gray = '0; pa.mean = '0; pa.bg_var = '0;
    pb.valid = 0; pb.h = '0; pb.s = '0; pb.v = '0; pb.gray = '0; pb.mean = '0; pb.bg_var = '0;
    forever begin
      @(negedge clk);
      pa.valid = pend_a;
      if (pend_a && m_fg[ay*8+ax]) begin
        pa.h = 9'(m_h[ay*8+ax]); pa.s = 8'd200; pa.v = 8'd200;
        pa.gray = 8'd100; pa.mean = 8'd103; pa.bg_var = 16'(m_var[ay*8+ax]);
      end else begin
        pa.h = '0; pa.s = '0; pa.v = '0; pa.gray = 8'd50; pa.mean = 8'd50; pa.bg_var = '0;
      end
      pend_a = pa.req; ax = int'(pa.x); ay = int'(pa.y);

      pb.valid = pend_b;
      if (pend_b && m_fg[by*8+bx]) begin
        pb.h = 9'(m_h[by*8+bx]); pb.s = 8'd200; pb.v = 8'd200;
        pb.gray = 8'd100; pb.mean = 8'd103; pb.bg_var = 16'(m_var[by*8+bx]);
      end else begin
        pb.h = '0; pb.s = '0; pb.v = '0; pb.gray = 8'd50; pb.mean = 8'd50; pb.bg_var = '0;
      end
      pend_b = pb.req; bx = int'(pb.x); by = int'(pb.y);
    end
  end

  task automatic load_map(input int v);
    for (int i = 0; i < 32; i++) begin
      m_fg[i] = 0; m_h[i] = 0; m_var[i] = 0;
    end
    for (int i = 0; i < 14; i++) begin
      if (ptab[i].vec == v) begin
        m_fg[ptab[i].y*8 + ptab[i].x]  = 1;
        m_h[ptab[i].y*8 + ptab[i].x]   = ptab[i].h;
        m_var[ptab[i].y*8 + ptab[i].x] = ptab[i].vr;
      end
    end
  endtask

  task automatic run_frame(input int v);
    int t, nreq;
    load_map(v);
    start = 1;
    @(negedge clk);
    start = 0;
    chk($sformatf("v%0d first req", v), int'(pa.req), 1);
    t = 0; nreq = 1;
    while (!a_valid && t < 300) begin
      @(negedge clk);
      t++;
      if (pa.req) nreq++;
    end
    chk($sformatf("v%0d req to valid cycles", v), t, 64);
    chk($sformatf("v%0d samples", v), nreq, 32);
    chk($sformatf("v%0d b valid lockstep", v), int'(b_valid), 1);
    chk($sformatf("v%0d frame_cnt", v), int'(a_fcnt), v + 1);
    for (int i = 0; i < 12; i++) begin
      if (etab[i].vec == v) begin
        chk_res("a", 1, etab[i], a_ux, a_uy, a_dx, a_dy, a_lx, a_ly, a_rx, a_ry, a_cnt, a_found);
        chk_res("b", 4, etab[i], b_ux, b_uy, b_dx, b_dy, b_lx, b_ly, b_rx, b_ry, b_cnt, b_found);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int t;
    bit seen;

    ptab[0]  = '{0, 3, 2, 120, 8};
    ptab[1]  = '{1, 3, 2, 120, 9};
    ptab[2]  = '{2, 0, 0, 350, 8};
    ptab[3]  = '{2, 4, 1, 200, 8};
    ptab[4]  = '{2, 7, 3, 10, 8};
    ptab[5]  = '{3, 1, 1, 120, 8};
    ptab[6]  = '{3, 1, 3, 120, 8};
    ptab[7]  = '{3, 5, 1, 120, 8};
    ptab[8]  = '{3, 5, 3, 120, 8};
    ptab[9]  = '{4, 2, 0, 120, 8};
    ptab[10] = '{4, 6, 2, 120, 8};
    ptab[11] = '{4, 0, 3, 120, 8};
    ptab[12] = '{5, 7, 0, 120, 8};
    ptab[13] = '{5, 0, 3, 10, 8};

    etab[0]  = '{0, 0, 1, 3, 2, 3, 2, 3, 2, 3, 2};
    etab[1]  = '{0, 1, 0, NF, NF, NF, NF, NF, NF, NF, NF};
    etab[2]  = '{1, 0, 0, NF, NF, NF, NF, NF, NF, NF, NF};
    etab[3]  = '{1, 1, 0, NF, NF, NF, NF, NF, NF, NF, NF};
    etab[4]  = '{2, 0, 0, NF, NF, NF, NF, NF, NF, NF, NF};
    etab[5]  = '{2, 1, 2, 0, 0, 7, 3, 0, 0, 7, 3};
    etab[6]  = '{3, 0, 4, 1, 1, 5, 3, 1, 3, 5, 1};
    etab[7]  = '{3, 1, 0, NF, NF, NF, NF, NF, NF, NF, NF};
    etab[8]  = '{4, 0, 3, 2, 0, 0, 3, 0, 3, 6, 2};
    etab[9]  = '{4, 1, 0, NF, NF, NF, NF, NF, NF, NF, NF};
    etab[10] = '{5, 0, 1, 7, 0, 7, 0, 7, 0, 7, 0};
    etab[11] = '{5, 1, 1, 0, 3, 0, 3, 0, 3, 0, 0};

    // ch0: green-ish hue 100..140; ch1: wrapping red 340..20.
    cfg_hmin = {9'd340, 9'd100};
    cfg_hmax = {9'd20,  9'd140};
    cfg_smin = {8'd100, 8'd100};
    cfg_smax = {8'd255, 8'd255};
    cfg_vmin = {8'd100, 8'd100};
    cfg_vmax = {8'd255, 8'd255};

    rst = 1; start = 0; continuous = 0;
    repeat (3) @(negedge clk);
    chk("reset busy",      int'(a_busy), 0);
    chk("reset valid",     int'(a_valid), 0);
    chk("reset req",       int'(pa.req), 0);
    chk("reset x",         int'(pa.x), 0);
    chk("reset y",         int'(pa.y), 0);
    chk("reset found",     int'(a_found), 0);
    chk("reset count",     int'(a_cnt), 0);
    chk("reset frame_cnt", int'(a_fcnt), 0);
    chk("reset up_x ch0",  sl(a_ux, 0), NF);
    chk("reset right_y ch1", sl(a_ry, 1), NF);
    rst = 0;

    for (int v = 0; v < 6; v++) run_frame(v);

    // Result buffer holds the last frame while idle.
    repeat (5) @(negedge clk);
    chk("hold busy", int'(a_busy), 0);
    chk("hold right_y ch1", sl(a_ry, 1), 0);
    chk("hold up_y ch1", sl(a_uy, 1), 3);
    chk("hold count ch0", int'(a_cnt[19:0]), 1);

    // Continuous mode: counts restart every frame.
    load_map(3);
    continuous = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int f = 0; f < 2; f++) begin
      t = 0;
      while (!a_valid && t < 300) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("cont f%0d valid seen", f), int'(a_valid), 1);
      chk($sformatf("cont f%0d frame_cnt", f), int'(a_fcnt), 7 + f);
      chk($sformatf("cont f%0d count ch0", f), int'(a_cnt[19:0]), 4);
      chk($sformatf("cont f%0d b found ch0", f), int'(b_found[0]), 1);
      chk($sformatf("cont f%0d b left_y ch0", f), sl(b_ly, 0), 3);
      @(negedge clk);
      chk($sformatf("cont f%0d req after valid", f), int'(pa.req), 1);
    end

    // Reset in the middle of the third frame.
    repeat (20) @(negedge clk);
    chk("mid-frame busy", int'(a_busy), 1);
    continuous = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst busy",      int'(a_busy), 0);
    chk("rst valid",     int'(a_valid), 0);
    chk("rst req",       int'(pa.req), 0);
    chk("rst x",         int'(pa.x), 0);
    chk("rst y",         int'(pa.y), 0);
    chk("rst frame_cnt", int'(a_fcnt), 0);
    chk("rst count",     int'(a_cnt), 0);
    chk("rst found",     int'(a_found), 0);
    chk("rst left_x ch0", sl(a_lx, 0), NF);
    chk("rst b down_y ch0", sl(b_dy, 0), NF);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_valid || b_valid || pa.req) seen = 1;
    end
    chk("no activity after reset", int'(seen), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/blob_extent_tracker.md
# blob_extent_tracker

Multi-channel foreground blob tracker for the camera datapath. It scans a frame by requesting pixel coordinates from the frame store, one request per sample, and subtracts background with a per-pixel mean/variance model. Each foreground pixel is classified against NCH programmable HSV windows, and the block tracks per-channel extreme points and pixel counts. Results are double-buffered, so the game/render logic always sees a stable, complete-frame result; the block supports single-shot or continuous scanning.

## Interface
Parameters:
- WIDTH, 640, frame width in pixels
- HEIGHT, 480, frame height in pixels
- STEP_X, 1, horizontal subsample step (≥1)
- STEP_Y, 1, vertical subsample step (≥1)
- NCH, 2, number of colour channels
- CW, 11, coordinate width
- MIN_CNT, 16, minimum matching pixels for a channel to report found
- NOT_FOUND, 2023, coordinate value reported when a channel is not found

Ports:
- i_clk, in, 1, clock
- i_rst, in, 1, synchronous active-high reset
- i_start, in, 1, start scan; ignored while o_busy
- i_continuous, in, 1, rescan automatically after each frame; sampled in S_OUT
- i_cfg_hmin / i_cfg_hmax, in, NCH*9, per-channel hue bounds 0..359; channel k at [9k+:9]
- i_cfg_smin / i_cfg_smax / i_cfg_vmin / i_cfg_vmax, in, NCH*8, per-channel S/V bounds
- o_req, out, 1, one-cycle strobe: o_x/o_y valid, fetch pixel
- o_x, o_y, out, CW, requested coordinate
- i_valid, in, 1, pixel data valid (response to o_req)
- i_h, in, 9; i_s, i_v, in, 8, pixel HSV
- i_gray, i_mean, in, 8, pixel gray and background mean
- i_var, in, 16, background variance threshold
- o_busy, out, 1, scan in progress
- o_valid, out, 1, one-cycle pulse: result buses updated
- o_up_x/y, o_down_x/y, o_left_x/y, o_right_x/y, out, NCH*CW each, per-channel extremes
- o_count, out, NCH*20, per-channel matching pixel count
- o_found, out, NCH, count ≥ MIN_CNT
- o_frame_cnt, out, 16, completed frames, wraps

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_OUT.
- S_IDLE: on i_start, go to S_REQ. Set x = y = 0. Clear the working registers: up/left = NOT_FOUND, down/right = 0, counts = 0.
- S_REQ: assert o_req for one cycle, then go to S_WAIT. i_valid is ignored in S_REQ.
- S_WAIT: hold until i_valid. On i_valid, process the pixel, then advance.
- Advance: if x+STEP_X ≥ WIDTH, set x = 0. Then, if y+STEP_Y ≥ HEIGHT, set y = 0 and go to S_OUT; otherwise y += STEP_Y and go to S_REQ. If x+STEP_X < WIDTH, x += STEP_X and go to S_REQ.
- Background test: d = |i_gray − i_mean| (8 bits); the pixel is background iff d*d (16 bits) ≤ i_var. Background pixels update nothing.
- Channel match (inclusive bounds): S and V must be in [min, max]. If hmin ≤ hmax, hue must be in [hmin, hmax]. If hmin > hmax, the hue window wraps and matches when h ≥ hmin or h ≤ hmax.
- On a channel match, update that channel's working registers independently of other channels:
  - count++, saturating at 2^20−1
  - up: replace when y < up_y
  - down: replace when y ≥ down_y
  - left: replace when x ≤ left_x
  - right: replace when x > right_x
- S_OUT:
  - Copy working registers to the output registers. For a channel with count < MIN_CNT, output all 8 coordinates as NOT_FOUND and o_found = 0; o_count still shows the true count.
  - Pulse o_valid and increment o_frame_cnt.
  - If i_continuous, clear the working registers and go to S_REQ. Otherwise go to S_IDLE.
- Output buses change only in the cycle o_valid is high.

## Timing
- Reset (i_rst at clock edge, from any state, including mid-scan):
  - state = S_IDLE
  - o_req, o_valid, o_busy, o_x, o_y, o_found, o_count, o_frame_cnt = 0
  - all coordinate outputs = NOT_FOUND
  - A partial frame is discarded.
- o_busy = 1 in S_REQ, S_WAIT and S_OUT.
- The first o_req occurs in the cycle after i_start is sampled.
- Minimum of 2 cycles per sample, when i_valid arrives in the first S_WAIT cycle. A full frame takes at least 2·ceil(WIDTH/STEP_X)·ceil(HEIGHT/STEP_Y)+1 cycles from the first o_req to o_valid.
- o_valid is asserted in the cycle after the last pixel's i_valid is accepted.
- In continuous mode, the next o_req occurs in the cycle after o_valid.
- i_start coincident with o_valid is ignored. i_start in the cycle after S_OUT→S_IDLE starts a new scan.

## Test plan
Common bench configuration: WIDTH=8, HEIGHT=4, STEP=1, NCH=2; i_valid returned the cycle after o_req unless stated. Pixels not listed are background (gray = mean).
- Single pixel: ch0 matching pixel at (3,2), MIN_CNT=1 -> o_valid after 32 samples; ch0 up/down/left/right all (3,2), count 1, found 1; ch1 all 2023, found 0.
- Background boundary: gray=100, mean=103 -> var=9 is background (count 0); var=8 is foreground (count 1).
- Hue wrap: ch1 hmin=340, hmax=20 -> h=350 and h=10 match, h=200 does not; ch1 count = 2.
- Tie rules: matches at (1,1), (1,3), (5,1), (5,3) -> up=(1,1), down=(5,3), left=(1,3), right=(5,1).
- MIN_CNT=4 with 3 matches -> o_found=0, coordinates 2023, o_count=3.
- Continuous mode and reset: i_continuous=1 -> o_valid every frame, o_frame_cnt 1, 2, 3, counts not accumulated across frames. i_rst asserted mid-frame 3 -> next cycle all outputs at reset values, state S_IDLE, no o_valid.
